// File: rtl/adt7420_poll_ctrl_if.sv
// Byte-engine command/handshake bundle between adt7420_poll_ctrl and the
// single-byte I2C engine. The controller takes the master side, the engine
// takes the slave side.
interface adt7420_poll_ctrl_if;
  logic       run;
  logic       start_cond;
  logic       stop_cond;
  logic       read_nWrite;
  logic       ack_nack_write;
  logic [7:0] wbyte;
  logic [7:0] rbyte;
  logic       done_nRunning;
  logic       error;

  modport master (
    output run, start_cond, stop_cond, read_nWrite, ack_nack_write, wbyte,
    input  rbyte, done_nRunning, error
  );

  modport slave (
    input  run, start_cond, stop_cond, read_nWrite, ack_nack_write, wbyte,
    output rbyte, done_nRunning, error
  );
endinterface

// File: rtl/adt7420_poll_ctrl.sv
// ADT7420 temperature poller: sequences five byte-engine transactions
// (addr+W, reg 0x00, addr+R, MSB w/ ACK, LSB w/ NACK+stop) periodically or
// on trig, publishes {MSB,LSB} with a one-cycle strobe, and tracks aborts.
// Optional macro CFG_WRITE_EN: one-time write of CFG_BYTE to register 0x03
// after reset, retried every POLL_CYC cycles until it succeeds.
module adt7420_poll_ctrl #(
  parameter logic [6:0]  DEV_ADDR    = 7'h48,
  parameter int unsigned POLL_CYC    = 250000,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [7:0]  CFG_BYTE    = 8'h80
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       trig,
  adt7420_poll_ctrl_if.master        eng,
  output logic [15:0]                temp,
  output logic                       temp_valid,
  output logic                       busy,
  output logic                       bus_err,
  output logic [7:0]                 err_count
);

  localparam int unsigned PW = $clog2(POLL_CYC);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [PW-1:0] PLAST = PW'(POLL_CYC - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT, S_ABORT
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] ptmr_q, ptmr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    msb_q, msb_d, lsb_q, lsb_d;
  logic [15:0]   temp_q, temp_d;
  logic          tv_q, tv_d;
  logic          busy_q, busy_d;
  logic          berr_q, berr_d;
  logic [7:0]    ecnt_q, ecnt_d;
  logic          run_q, run_d;
  logic          start_q, start_d, stop_q, stop_d;
  logic          rnw_q, rnw_d, ack_q, ack_d;
  logic [7:0]    wbyte_q, wbyte_d;
  logic          cfg_pend;
  logic [2:0]    last_idx;

`ifdef CFG_WRITE_EN
  logic cfg_pend_q, cfg_pend_d, cfg_retry_q, cfg_retry_d;
  assign cfg_pend = cfg_pend_q;
`else
  assign cfg_pend = 1'b0;
`endif

  assign last_idx = cfg_pend ? 3'd2 : 3'd4;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ptmr_q  <= '0;
      tmo_q   <= '0;
      msb_q   <= '0;
      lsb_q   <= '0;
      temp_q  <= '0;
      tv_q    <= 1'b0;
      busy_q  <= 1'b0;
      berr_q  <= 1'b0;
      ecnt_q  <= '0;
      run_q   <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      rnw_q   <= 1'b0;
      ack_q   <= 1'b0;
      wbyte_q <= '0;
`ifdef CFG_WRITE_EN
      cfg_pend_q  <= 1'b1;
      cfg_retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptmr_q  <= ptmr_d;
      tmo_q   <= tmo_d;
      msb_q   <= msb_d;
      lsb_q   <= lsb_d;
      temp_q  <= temp_d;
      tv_q    <= tv_d;
      busy_q  <= busy_d;
      berr_q  <= berr_d;
      ecnt_q  <= ecnt_d;
      run_q   <= run_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      rnw_q   <= rnw_d;
      ack_q   <= ack_d;
      wbyte_q <= wbyte_d;
`ifdef CFG_WRITE_EN
      cfg_pend_q  <= cfg_pend_d;
      cfg_retry_q <= cfg_retry_d;
`endif
    end
  end

  // Next-state, command decode and status update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptmr_d  = ptmr_q;
    tmo_d   = tmo_q;
    msb_d   = msb_q;
    lsb_d   = lsb_q;
    temp_d  = temp_q;
    tv_d    = 1'b0;
    berr_d  = berr_q;
    ecnt_d  = ecnt_q;
    start_d = start_q;
    stop_d  = stop_q;
    rnw_d   = rnw_q;
    ack_d   = ack_q;
    wbyte_d = wbyte_q;
`ifdef CFG_WRITE_EN
    cfg_pend_d  = cfg_pend_q;
    cfg_retry_d = cfg_retry_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef CFG_WRITE_EN
        // Config pending: start at once, or after POLL_CYC when retrying.
        if (cfg_pend_q) begin
          if (!cfg_retry_q || ptmr_q == PLAST) begin
            ptmr_d  = '0;
            state_d = S_LOAD;
          end else begin
            ptmr_d = ptmr_q + 1'b1;
          end
        end else
`endif
        if (trig || (en && ptmr_q == PLAST)) begin
          ptmr_d  = '0;
          state_d = S_LOAD;
        end else if (en) begin
          ptmr_d = ptmr_q + 1'b1;
        end else begin
          ptmr_d = '0;
        end
      end
      S_LOAD: begin
        start_d = 1'b0;
        stop_d  = 1'b0;
        rnw_d   = 1'b0;
        ack_d   = 1'b0;
        wbyte_d = '0;
        if (cfg_pend) begin
          case (idx_q)
            3'd0:    begin start_d = 1'b1; wbyte_d = {DEV_ADDR, 1'b0}; end
            3'd1:    wbyte_d = 8'h03;
            default: begin stop_d = 1'b1; wbyte_d = CFG_BYTE; end
          endcase
        end else begin
          case (idx_q)
            3'd0:    begin start_d = 1'b1; wbyte_d = {DEV_ADDR, 1'b0}; end
            3'd1:    wbyte_d = 8'h00;
            3'd2:    begin start_d = 1'b1; wbyte_d = {DEV_ADDR, 1'b1}; end
            3'd3:    begin rnw_d = 1'b1; ack_d = 1'b1; end
            default: begin rnw_d = 1'b1; stop_d = 1'b1; end
          endcase
        end
        tmo_d   = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!eng.done_nRunning) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end else if (tmo_q == TLAST) begin
          state_d = S_ABORT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (eng.done_nRunning) begin
          if (eng.error) begin
            state_d = S_ABORT;
          end else begin
            if (!cfg_pend && idx_q == 3'd3) msb_d = eng.rbyte;
            if (!cfg_pend && idx_q == 3'd4) lsb_d = eng.rbyte;
            state_d = S_NEXT;
          end
        end else if (tmo_q == TLAST) begin
          state_d = S_ABORT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (idx_q == last_idx) begin
          idx_d   = '0;
          state_d = S_IDLE;
          if (cfg_pend) begin
`ifdef CFG_WRITE_EN
            cfg_pend_d  = 1'b0;
            cfg_retry_d = 1'b0;
`endif
          end else begin
            temp_d = {msb_q, lsb_q};
            tv_d   = 1'b1;
            berr_d = 1'b0;
          end
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_LOAD;
        end
      end
      S_ABORT: begin
        berr_d  = 1'b1;
        if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
        idx_d   = '0;
        state_d = S_IDLE;
`ifdef CFG_WRITE_EN
        if (cfg_pend_q) cfg_retry_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CFG_WRITE_EN
    busy_d = (state_d != S_IDLE) || cfg_pend_d;
`else
    busy_d = (state_d != S_IDLE);
`endif
    run_d = (state_d == S_ISSUE);
  end

  assign eng.run            = run_q;
  assign eng.start_cond     = start_q;
  assign eng.stop_cond      = stop_q;
  assign eng.read_nWrite    = rnw_q;
  assign eng.ack_nack_write = ack_q;
  assign eng.wbyte          = wbyte_q;
  assign temp               = temp_q;
  assign temp_valid         = tv_q;
  assign busy               = busy_q;
  assign bus_err            = berr_q;
  assign err_count          = ecnt_q;

endmodule
